// File: rtl/html_tokenizer_if.sv
// Character-in / token-out channel of the HTML tokenizer.
// The tokenizer is the master; the reader/consumer side is the slave.
interface html_tokenizer_if #(
    parameter int MAX_NAME = 8
);
    logic [7:0]            in_char;
    logic                  in_finished;
    logic                  in_pause;
    logic                  token_valid;
    logic                  token_ready;
    logic [1:0]            token_type;
    logic [7:0]            token_char;
    logic [8*MAX_NAME-1:0] token_name;
    logic [3:0]            token_len;

    modport master (
        input  in_char, in_finished, token_ready,
        output in_pause, token_valid, token_type, token_char, token_name, token_len
    );

    modport slave (
        output in_char, in_finished, token_ready,
        input  in_pause, token_valid, token_type, token_char, token_name, token_len
    );
endinterface

// File: rtl/html_tokenizer.sv
// Streaming HTML tokenizer: turns a character stream into TEXT/START/END/EOF
// tokens held in a single-entry output slot with valid/ready handshake.
module html_tokenizer #(
    parameter int MAX_NAME = 8
) (
    input  logic           clock,
    input  logic           state_enable,
    html_tokenizer_if.master bus
);
    localparam int NW = 8 * MAX_NAME;
    localparam logic [1:0] TT_TEXT = 2'd0, TT_START = 2'd1, TT_END = 2'd2, TT_EOF = 2'd3;
    localparam logic [7:0] CH_LT = 8'h3C, CH_GT = 8'h3E, CH_SL = 8'h2F;

    typedef enum logic [2:0] {
        ST_DATA, ST_TAG_OPEN, ST_TAG_NAME, ST_END_OPEN,
        ST_END_NAME, ST_IN_TAG, ST_SKIP, ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [1:0]      type_q, type_d;
    logic [7:0]      char_q, char_d;
    logic [NW-1:0]   name_q, name_d;
    logic [3:0]      len_q, len_d;
    logic [NW-1:0]   buf_q, buf_d;
    logic [3:0]      blen_q, blen_d;
    logic            frozen_q, frozen_d;

    logic [7:0]      c, lc;
    logic            is_letter, is_digit, is_alnum, pause, take, eof;
    logic [NW-1:0]   buf_app;
    logic [3:0]      blen_app;
    logic            ld;
    logic [1:0]      ld_type;
    logic [7:0]      ld_char;

    always_comb begin
        c         = bus.in_char;
        is_letter = ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
        is_digit  = (c >= 8'h30) && (c <= 8'h39);
        is_alnum  = is_letter || is_digit;
        lc        = ((c >= 8'h41) && (c <= 8'h5A)) ? c + 8'h20 : c;
        pause     = (valid_q & ~bus.token_ready) | (state_q == ST_DONE);
        take      = ~pause & ~bus.in_finished & (c != 8'h00);
        eof       = ~pause & bus.in_finished;

        // Characters past MAX_NAME match no byte lane and are silently dropped.
        buf_app = buf_q;
        for (int i = 0; i < MAX_NAME; i++) begin
            if (blen_q == 4'(i)) buf_app[8*i +: 8] = lc;
        end
        blen_app = (blen_q < 4'(MAX_NAME)) ? blen_q + 4'd1 : blen_q;

        state_d  = state_q;
        valid_d  = valid_q & ~bus.token_ready;
        type_d   = type_q;
        char_d   = char_q;
        name_d   = name_q;
        len_d    = len_q;
        buf_d    = buf_q;
        blen_d   = blen_q;
        frozen_d = frozen_q;
        ld       = 1'b0;
        ld_type  = TT_TEXT;
        ld_char  = 8'h00;

        if (eof) begin
            ld      = 1'b1;
            ld_type = TT_EOF;
            state_d = ST_DONE;
            buf_d   = '0;
            blen_d  = '0;
        end else if (take) begin
            unique case (state_q)
                ST_DATA: begin
                    if (c == CH_LT) begin
                        state_d = ST_TAG_OPEN;
                        buf_d   = '0;
                        blen_d  = '0;
                    end else begin
                        ld      = 1'b1;
                        ld_char = c;
                    end
                end
                ST_TAG_OPEN: begin
                    if (c == CH_SL) begin
                        state_d = ST_END_OPEN;
                    end else if (is_letter) begin
                        state_d = ST_TAG_NAME;
                        buf_d   = buf_app;
                        blen_d  = blen_app;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
                ST_TAG_NAME: begin
                    if (is_alnum) begin
                        buf_d  = buf_app;
                        blen_d = blen_app;
                    end else if (c == CH_GT) begin
                        ld      = 1'b1;
                        ld_type = TT_START;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IN_TAG;
                    end
                end
                ST_IN_TAG: begin
                    if (c == CH_GT) begin
                        ld      = 1'b1;
                        ld_type = TT_START;
                        state_d = ST_DATA;
                    end
                end
                ST_END_OPEN: begin
                    if (is_letter) begin
                        state_d  = ST_END_NAME;
                        buf_d    = buf_app;
                        blen_d   = blen_app;
                        frozen_d = 1'b0;
                    end else if (c == CH_GT) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
                ST_END_NAME: begin
                    if (c == CH_GT) begin
                        ld      = 1'b1;
                        ld_type = TT_END;
                        state_d = ST_DATA;
                    end else if (!is_alnum) begin
                        frozen_d = 1'b1;
                    end else if (!frozen_q) begin
                        buf_d  = buf_app;
                        blen_d = blen_app;
                    end
                end
                ST_SKIP: begin
                    if (c == CH_GT) state_d = ST_DATA;
                end
                default: ;
            endcase
        end

        if (ld) begin
            valid_d = 1'b1;
            type_d  = ld_type;
            char_d  = ld_char;
            name_d  = ((ld_type == TT_START) || (ld_type == TT_END)) ? buf_q : '0;
            len_d   = ((ld_type == TT_START) || (ld_type == TT_END)) ? blen_q : 4'd0;
        end
    end

    always_ff @(posedge clock or negedge state_enable) begin
        if (!state_enable) begin
            state_q  <= ST_DATA;
            valid_q  <= 1'b0;
            type_q   <= TT_TEXT;
            char_q   <= 8'h00;
            name_q   <= '0;
            len_q    <= 4'd0;
            buf_q    <= '0;
            blen_q   <= 4'd0;
            frozen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
            char_q   <= char_d;
            name_q   <= name_d;
            len_q    <= len_d;
            buf_q    <= buf_d;
            blen_q   <= blen_d;
            frozen_q <= frozen_d;
        end
    end

    assign bus.in_pause    = pause;
    assign bus.token_valid = valid_q;
    assign bus.token_type  = type_q;
    assign bus.token_char  = char_q;
    assign bus.token_name  = name_q;
    assign bus.token_len   = len_q;
endmodule

// File: doc/html_tokenizer.md
HTML_TOKENIZER -- requirements
Module: html_tokenizer

Interface
REQ-001 SHALL have parameter MAX_NAME, default 8, maximum tag-name length in characters.
REQ-002 SHALL have port clock, input, 1 bit, sole clock, all state on rising edge.
REQ-003 SHALL have port state_enable, input, 1 bit, reset: asynchronous, active-low (0 = reset, 1 = run).
REQ-004 SHALL have port in_char, input, 8 bits (`CHAR_BITES), upstream character stream.
REQ-005 SHALL have port in_finished, input, 1 bit, upstream end-of-file flag.
REQ-006 SHALL have port in_pause, output, 1 bit, backpressure to upstream reader.
REQ-007 SHALL have port token_valid, output, 1 bit, token slot holds a token.
REQ-008 SHALL have port token_ready, input, 1 bit, downstream accepts token.
REQ-009 SHALL have port token_type, output, 2 bits: 0 TEXT, 1 START, 2 END, 3 EOF.
REQ-010 SHALL have port token_char, output, 8 bits, character for TEXT tokens, 0 otherwise.
REQ-011 SHALL have port token_name, output, 8*MAX_NAME bits, tag name, first char in [7:0], unused bytes 0.
REQ-012 SHALL have port token_len, output, 4 bits, tag-name length 0..MAX_NAME.

Function
REQ-013 SHALL consume in_char at a rising edge only when in_pause=0, in_finished=0 and in_char!=0; in_char=0 SHALL be ignored.
REQ-014 SHALL drive in_pause = (token_valid & ~token_ready) | (state==DONE), combinationally.
REQ-015 SHALL transfer a token on any edge with token_valid=1 and token_ready=1; a new token MAY be loaded on that same edge.
REQ-016 SHALL hold token_type/char/name/len stable while token_valid=1 and token_ready=0.
REQ-017 SHALL implement states DATA, TAG_OPEN, TAG_NAME, END_OPEN, END_NAME, IN_TAG, SKIP, DONE.
REQ-018 DATA: '<' -> TAG_OPEN; any other char -> emit TEXT with token_char=char, stay DATA.
REQ-019 TAG_OPEN: '/' -> END_OPEN; letter -> TAG_NAME with name=that char, len=1; other -> SKIP.
REQ-020 TAG_NAME: letter/digit -> append; whitespace or '/' -> IN_TAG; '>' -> emit START, go DATA.
REQ-021 IN_TAG: every char except '>' discarded (attributes, self-close); '>' -> emit START, go DATA.
REQ-022 END_OPEN: letter -> END_NAME, len=1; '>' -> DATA, no token; other -> SKIP.
REQ-023 END_NAME: letter/digit -> append; '>' -> emit END, go DATA; other chars discarded, name frozen.
REQ-024 SKIP (comments, doctype, malformed): discard until '>', then DATA, no token.
REQ-025 SHALL fold 'A'-'Z' to lowercase (+0x20) when stored in token_name.
REQ-026 SHALL drop name characters beyond MAX_NAME; token_len SHALL saturate at MAX_NAME.
REQ-027 SHALL clear name buffer and len on every entry to TAG_OPEN.
REQ-028 On in_finished=1 in any state except DONE, with slot free or transferring, SHALL emit EOF (name 0, len 0, char 0), discard any partial tag, enter DONE.
REQ-029 If in_finished=1 while slot is full and stalled, EOF SHALL wait until the slot is freed.
REQ-030 DONE SHALL emit no further tokens until reset.

Reset
REQ-031 While state_enable=0: token_valid=0, token_type=0, token_char=0, token_name=0, token_len=0, state=DATA, in_pause=0.
REQ-032 Reset assertion mid-tag or mid-stall SHALL discard the pending token and partial name immediately, without a clock edge.

Verification
REQ-033 "<p>hi</p>", token_ready=1 -> START "p" len1, TEXT 'h', TEXT 'i', END "p" len1, EOF.
REQ-034 "<DIV class=x>" -> single START, token_name "div", len 3; attribute chars produce no tokens.
REQ-035 "<abcdefghij>" -> START, token_name "abcdefgh", len 8.
REQ-036 "ab", token_ready low 5 cycles after TEXT 'a' -> in_pause=1 those 5 cycles, 'a' held stable, then TEXT 'b', no char lost or duplicated.
REQ-037 "<!-- x -->a" -> TEXT 'a', EOF only.
REQ-038 "<ta" then state_enable=0 for 1 cycle, then "<b>" -> all outputs 0 during reset, then START "b" len 1.
